// File: rtl/motor_pkg.sv
// Shared constants and types for the two-track motor arbiter:
// H-bridge direction codes, grant codes and controller states.
package motor_pkg;

   localparam logic [3:0] DIR_STOP     = 4'b0000;
   localparam logic [3:0] DIR_FORWARD  = 4'b1001;
   localparam logic [3:0] DIR_BACKWARD = 4'b0110;
   localparam logic [3:0] DIR_LEFT     = 4'b1010;
   localparam logic [3:0] DIR_RIGHT    = 4'b0101;

   localparam int DUTY_MIN = 1;

   typedef enum logic [1:0] {
      GRANT_NONE  = 2'b00,
      GRANT_AUTO  = 2'b01,
      GRANT_MAN   = 2'b10,
      GRANT_ESTOP = 2'b11
   } grant_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DEAD  = 2'd2,
      ST_ESTOP = 2'd3
   } state_e;

endpackage

// File: rtl/motor_arbiter_if.sv
// Command-source and driver-side signal bundle of the motor arbiter.
// master = command sources / H-bridge side, slave = the arbiter itself.
interface motor_arbiter_if #(
   parameter int DUTY_W = 20
);
   logic              auto_valid;
   logic [3:0]        auto_in;
   logic [DUTY_W-1:0] auto_duty_A;
   logic [DUTY_W-1:0] auto_duty_B;
   logic              man_valid;
   logic [3:0]        man_in;
   logic [DUTY_W-1:0] man_duty_A;
   logic [DUTY_W-1:0] man_duty_B;
   logic              estop_ir;
   logic              estop_cur;
   logic [3:0]        in;
   logic [DUTY_W-1:0] duty_cycle_A;
   logic [DUTY_W-1:0] duty_cycle_B;
   logic [1:0]        grant;
   logic              busy;

   modport master (
      output auto_valid, auto_in, auto_duty_A, auto_duty_B,
      output man_valid, man_in, man_duty_A, man_duty_B,
      output estop_ir, estop_cur,
      input  in, duty_cycle_A, duty_cycle_B, grant, busy
   );

   modport slave (
      input  auto_valid, auto_in, auto_duty_A, auto_duty_B,
      input  man_valid, man_in, man_duty_A, man_duty_B,
      input  estop_ir, estop_cur,
      output in, duty_cycle_A, duty_cycle_B, grant, busy
   );
endinterface

// File: rtl/duty_ramp.sv
// Per-track soft-start duty register: ramps up by RAMP_STEP on each tick,
// drops to a lower target at once, and can be forced to the minimum duty.
module duty_ramp #(
   parameter int DUTY_W    = 20,
   parameter int RAMP_STEP = 25000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] target,
   input  logic              tick,
   input  logic              load_min,
   input  logic              drop_immediate,
   output logic [DUTY_W-1:0] duty,
   output logic              at_target
);
   import motor_pkg::*;

   localparam logic [DUTY_W-1:0] MIN_D  = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(RAMP_STEP);

   logic [DUTY_W-1:0] duty_reg, duty_next;
   logic [DUTY_W:0]   sum;

   // One extra bit on the sum so a large step can never wrap past the target.
   always_comb begin
      sum       = {1'b0, duty_reg} + STEP_X;
      duty_next = duty_reg;
      if (load_min) begin
         duty_next = MIN_D;
      end else if (drop_immediate && (target < duty_reg)) begin
         duty_next = target;
      end else if (tick && (duty_reg < target)) begin
         duty_next = (sum >= {1'b0, target}) ? target : sum[DUTY_W-1:0];
      end
   end

   // Describes the duty that will be loaded at the coming edge.
   assign at_target = (duty_next >= target);
   assign duty      = duty_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_reg <= MIN_D;
      end else begin
         duty_reg <= duty_next;
      end
   end

endmodule

// File: rtl/motor_arbiter.sv
// Two-track motor command arbiter: estop > manual > auto priority, dead time
// on every direction reversal or safety restart, and per-track soft start.
module motor_arbiter #(
   parameter int DUTY_W      = 20,
   parameter int DUTY_MAX    = 250000,
   parameter int DEAD_CYCLES = 50000,
   parameter int RAMP_STEP   = 25000,
   parameter int RAMP_DIV    = 100000
) (
   input logic             clk,
   input logic             rst,
   motor_arbiter_if.slave  bus
);
   import motor_pkg::*;

   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
   localparam logic [DUTY_W-1:0] MIN_D     = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(DUTY_MAX);

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      if (d == '0)
         return MIN_D;
      if (d > MAX_D)
         return MAX_D;
      return d;
   endfunction

   logic              estop;
   logic [3:0]        tgt_dir;
   grant_e            tgt_grant;
   logic [DUTY_W-1:0] raw_duty [2];
   logic [DUTY_W-1:0] tgt_duty [2];
   logic [DUTY_W-1:0] duty     [2];
   logic              at_tgt   [2];

   state_e            state_reg, state_next;
   logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
   logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
   logic [3:0]        in_reg, in_next;
   grant_e            grant_reg, grant_next;
   logic              busy_reg, busy_next;
   logic [3:0]        run_dir;
   logic              stay_run, ramp_tick, load_min;

   // Source selection; the estop target stays STOP so nothing leaks through.
   always_comb begin
      estop       = bus.estop_ir | bus.estop_cur;
      tgt_grant   = GRANT_NONE;
      tgt_dir     = DIR_STOP;
      raw_duty[0] = MIN_D;
      raw_duty[1] = MIN_D;
      if (estop) begin
         tgt_grant = GRANT_ESTOP;
      end else if (bus.man_valid) begin
         tgt_grant   = GRANT_MAN;
         tgt_dir     = bus.man_in;
         raw_duty[0] = bus.man_duty_A;
         raw_duty[1] = bus.man_duty_B;
      end else if (bus.auto_valid) begin
         tgt_grant   = GRANT_AUTO;
         tgt_dir     = bus.auto_in;
         raw_duty[0] = bus.auto_duty_A;
         raw_duty[1] = bus.auto_duty_B;
      end
   end

   always_comb begin
      state_next = state_reg;
      run_dir    = in_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (tgt_dir != DIR_STOP) begin
               state_next = ST_RUN;
               run_dir    = tgt_dir;
            end
         end
         ST_RUN: begin
            if (tgt_dir == DIR_STOP)
               state_next = ST_IDLE;
            else if (tgt_dir != in_reg)
               state_next = ST_DEAD;
         end
         ST_DEAD: begin
            // The target is only looked at again once the dead time is over.
            if (dead_cnt_reg == DEAD_LAST) begin
               if (tgt_dir == DIR_STOP) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_RUN;
                  run_dir    = tgt_dir;
               end
            end
         end
         ST_ESTOP: state_next = ST_DEAD;
         default:  state_next = ST_IDLE;
      endcase
      if (estop)
         state_next = ST_ESTOP;

      stay_run      = (state_reg == ST_RUN) && (state_next == ST_RUN);
      ramp_tick     = stay_run && (tick_cnt_reg == TICK_LAST);
      load_min      = !stay_run;
      tick_cnt_next = (stay_run && !ramp_tick) ? tick_cnt_reg + 1'b1 : '0;
      dead_cnt_next = ((state_reg == ST_DEAD) && (state_next == ST_DEAD))
                      ? dead_cnt_reg + 1'b1 : '0;

      in_next    = (state_next == ST_RUN) ? run_dir : DIR_STOP;
      grant_next = (state_next == ST_ESTOP) ? GRANT_ESTOP : tgt_grant;
      busy_next  = (state_next == ST_DEAD) ||
                   ((state_next == ST_RUN) && !(at_tgt[0] && at_tgt[1]));
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_track
         assign tgt_duty[gi] = (tgt_dir == DIR_STOP) ? MIN_D : clamp_duty(raw_duty[gi]);

         duty_ramp #(
            .DUTY_W    (DUTY_W),
            .RAMP_STEP (RAMP_STEP)
         ) u_ramp (
            .clk            (clk),
            .rst            (rst),
            .target         (tgt_duty[gi]),
            .tick           (ramp_tick),
            .load_min       (load_min),
            .drop_immediate (stay_run),
            .duty           (duty[gi]),
            .at_target      (at_tgt[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         dead_cnt_reg <= '0;
         tick_cnt_reg <= '0;
         in_reg       <= DIR_STOP;
         grant_reg    <= GRANT_NONE;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         dead_cnt_reg <= dead_cnt_next;
         tick_cnt_reg <= tick_cnt_next;
         in_reg       <= in_next;
         grant_reg    <= grant_next;
         busy_reg     <= busy_next;
      end
   end

   assign bus.in           = in_reg;
   assign bus.grant        = grant_reg;
   assign bus.busy         = busy_reg;
   assign bus.duty_cycle_A = duty[0];
   assign bus.duty_cycle_B = duty[1];

endmodule

// File: tb/tb_motor_arbiter.sv
// Directed bench for motor_arbiter: a per-step vector table plus hand-written
// asynchronous reset sequences (mid-ramp and mid-dead-time).
module tb_motor_arbiter;

   localparam logic [3:0] STP = 4'b0000;
   localparam logic [3:0] FWD = 4'b1001;
   localparam logic [3:0] BWD = 4'b0110;
   localparam logic [3:0] LFT = 4'b1010;
   localparam logic [3:0] RGT = 4'b0101;

   typedef struct {
      logic        av;
      logic [3:0]  ai;
      logic [19:0] aa, ab;
      logic        mv;
      logic [3:0]  mi;
      logic [19:0] ma, mb;
      logic        eir, ecur;
      int          ncyc;
      logic [3:0]  e_in;
      logic [19:0] e_a, e_b;
      logic [1:0]  e_grant;
      logic        e_busy;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs[$];

   motor_arbiter_if #(.DUTY_W(20)) bus ();

   motor_arbiter #(
      .DUTY_W      (20),
      .DUTY_MAX    (250000),
      .DEAD_CYCLES (10),
      .RAMP_STEP   (50000),
      .RAMP_DIV    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input logic av, input logic [3:0] ai, input logic [19:0] aa, input logic [19:0] ab,
      input logic mv, input logic [3:0] mi, input logic [19:0] ma, input logic [19:0] mb,
      input logic eir, input logic ecur, input int n,
      input logic [3:0] e_in, input logic [19:0] e_a, input logic [19:0] e_b,
      input logic [1:0] e_grant, input logic e_busy);
      vec_t v;
      v.av = av; v.ai = ai; v.aa = aa; v.ab = ab;
      v.mv = mv; v.mi = mi; v.ma = ma; v.mb = mb;
      v.eir = eir; v.ecur = ecur; v.ncyc = n;
      v.e_in = e_in; v.e_a = e_a; v.e_b = e_b; v.e_grant = e_grant; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] e_in, input logic [19:0] e_a,
                                input logic [19:0] e_b, input logic [1:0] e_g, input logic e_busy);
      chk({tag, ".in"},    32'(bus.in),           32'(e_in));
      chk({tag, ".dutyA"}, 32'(bus.duty_cycle_A), 32'(e_a));
      chk({tag, ".dutyB"}, 32'(bus.duty_cycle_B), 32'(e_b));
      chk({tag, ".grant"}, 32'(bus.grant),        32'(e_g));
      chk({tag, ".busy"},  32'(bus.busy),         32'(e_busy));
   endtask

   task automatic drive(input logic av, input logic [3:0] ai, input logic [19:0] aa,
                        input logic [19:0] ab, input logic mv, input logic [3:0] mi,
                        input logic [19:0] ma, input logic [19:0] mb,
                        input logic eir, input logic ecur);
      bus.auto_valid = av;  bus.auto_in = ai;  bus.auto_duty_A = aa; bus.auto_duty_B = ab;
      bus.man_valid  = mv;  bus.man_in  = mi;  bus.man_duty_A  = ma; bus.man_duty_B  = mb;
      bus.estop_ir   = eir; bus.estop_cur = ecur;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      drive(0, STP, 0, 0, 0, STP, 0, 0, 0, 0);

      // reset values after release, no request
      vecs.push_back(mk(0,STP,0,0,         0,STP,0,0,           0,0, 3, STP,1,1,2'b00,0));
      // soft start, auto FORWARD 90000/90000
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 1, FWD,1,1,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 3, FWD,1,1,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 1, FWD,50001,50001,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 3, FWD,50001,50001,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 1, FWD,90000,90000,2'b01,0));
      // reversal to BACKWARD: 10 dead cycles then ramp from 1
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 1, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 9, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 1, BWD,1,1,2'b01,1));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 4, BWD,50001,50001,2'b01,1));
      // overcurrent mid-ramp, then release and wait out dead time
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,1, 1, STP,1,1,2'b11,0));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,1, 3, STP,1,1,2'b11,0));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 1, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 9, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,BWD,90000,90000, 0,STP,0,0,           0,0, 1, BWD,1,1,2'b01,1));
      // manual LEFT over auto, duty clamp to 250000
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,300000,300000, 0,0, 1, STP,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,300000,300000, 0,0, 9, STP,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,300000,300000, 0,0, 1, LFT,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,300000,300000, 0,0,16, LFT,200001,200001,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,300000,300000, 0,0, 4, LFT,250000,250000,2'b10,0));
      // immediate decrease, and a zero duty request maps to 1
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,1,300000,      0,0, 1, LFT,1,250000,2'b10,0));
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,0,300000,      0,0, 1, LFT,1,250000,2'b10,0));
      // manual drops with auto FORWARD valid: dead time, then FORWARD
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 1, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 9, STP,1,1,2'b01,1));
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           0,0, 1, FWD,1,1,2'b01,1));
      vecs.push_back(mk(0,STP,0,0,         0,STP,0,0,           0,0, 1, STP,1,1,2'b00,0));
      // IR stop from IDLE; release together with a manual request goes DEAD first
      vecs.push_back(mk(1,FWD,90000,90000, 0,STP,0,0,           1,0, 1, STP,1,1,2'b11,0));
      vecs.push_back(mk(1,FWD,90000,90000, 1,RGT,1000,0,        0,0, 1, STP,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,RGT,1000,0,        0,0, 9, STP,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,RGT,1000,0,        0,0, 1, RGT,1,1,2'b10,1));
      vecs.push_back(mk(1,FWD,90000,90000, 1,RGT,1000,0,        0,0, 4, RGT,1000,1,2'b10,0));
      // estop together with a reversal: estop wins; then dead time expires into IDLE
      vecs.push_back(mk(1,FWD,90000,90000, 1,LFT,1000,0,        1,0, 1, STP,1,1,2'b11,0));
      vecs.push_back(mk(0,STP,0,0,         0,STP,0,0,           0,0, 1, STP,1,1,2'b00,1));
      vecs.push_back(mk(0,STP,0,0,         0,STP,0,0,           0,0, 9, STP,1,1,2'b00,1));
      vecs.push_back(mk(0,STP,0,0,         0,STP,0,0,           0,0, 1, STP,1,1,2'b00,0));

      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_held", STP, 1, 1, 2'b00, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].av, vecs[i].ai, vecs[i].aa, vecs[i].ab,
               vecs[i].mv, vecs[i].mi, vecs[i].ma, vecs[i].mb,
               vecs[i].eir, vecs[i].ecur);
         step(vecs[i].ncyc);
         check_outputs($sformatf("row%0d", i), vecs[i].e_in, vecs[i].e_a,
                       vecs[i].e_b, vecs[i].e_grant, vecs[i].e_busy);
         $display("row %0d: in=%b A=%0d B=%0d grant=%b busy=%b", i, bus.in,
                  bus.duty_cycle_A, bus.duty_cycle_B, bus.grant, bus.busy);
      end

      // asynchronous reset in the middle of a ramp
      drive(1, FWD, 90000, 90000, 0, STP, 0, 0, 0, 0);
      step(6);
      chk("ramp_pre_reset.dutyA", 32'(bus.duty_cycle_A), 32'd50001);
      #3;
      rst = 1'b1;
      #1;
      check_outputs("async_rst_ramp", STP, 1, 1, 2'b00, 0);
      $display("async reset mid-ramp: in=%b A=%0d grant=%b", bus.in, bus.duty_cycle_A, bus.grant);
      drive(0, STP, 0, 0, 0, STP, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step(3);
      check_outputs("post_rst_idle", STP, 1, 1, 2'b00, 0);
      $display("after release: in=%b A=%0d grant=%b busy=%b", bus.in, bus.duty_cycle_A,
               bus.grant, bus.busy);

      // asynchronous reset in the middle of dead time; restart needs no dead time
      drive(1, FWD, 90000, 90000, 0, STP, 0, 0, 0, 0);
      step(2);
      drive(1, BWD, 90000, 90000, 0, STP, 0, 0, 0, 0);
      step(3);
      chk("dead_pre_reset.busy", 32'(bus.busy), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check_outputs("async_rst_dead", STP, 1, 1, 2'b00, 0);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      check_outputs("restart_after_rst", BWD, 1, 1, 2'b01, 1);
      $display("restart after reset: in=%b grant=%b busy=%b", bus.in, bus.grant, bus.busy);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_arbiter.md
# motor_arbiter

Arbitrates the two-track motor command between the autonomous line-following steering controller, a manual/remote command source and the safety stop inputs (IR obstacle, overcurrent). Sits between the command sources and the PWM generators / H-bridge driver. Enforces H-bridge dead time on every direction reversal and soft-start ramping of duty. All outputs are registered.

## Interface
- DUTY_W, 20: duty-cycle width in bits.
- DUTY_MAX, 250000: upper clamp for any granted duty.
- DEAD_CYCLES, 50000: stop interval inserted on a direction change (0.5 ms at 100 MHz); must be ≥1.
- RAMP_STEP, 25000: maximum duty increase per ramp tick.
- RAMP_DIV, 100000: clock cycles per ramp tick; must be ≥1.

- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- auto_valid  input  1  autonomous steering command valid.
- auto_in  input  4  autonomous direction code.
- auto_duty_A / auto_duty_B  input  DUTY_W  autonomous left/right duty.
- man_valid  input  1  manual command valid.
- man_in  input  4  manual direction code.
- man_duty_A / man_duty_B  input  DUTY_W  manual left/right duty.
- estop_ir  input  1  IR obstacle stop, level.
- estop_cur  input  1  overcurrent stop, level.
- in  output  4  H-bridge direction code to the driver.
- duty_cycle_A / duty_cycle_B  output  DUTY_W  left/right track duty.
- grant  output  2  source driving the outputs: 00 none, 01 auto, 10 manual, 11 estop.
- busy  output  1  high in DEAD, or while either duty is below its target.

## Operation
- Priority, evaluated every cycle: estop_ir|estop_cur > man_valid > auto_valid > none.
- Target when no source is valid: in=STOP, duty 1.
- Target duty is clamped to DUTY_MAX. A duty of 0 maps to 1. A target whose in=STOP forces both target duties to 1.
- States: IDLE (outputs STOP), RUN, DEAD, ESTOP.
- Any state, estop high → ESTOP. In ESTOP: in=STOP, duties=1, grant=11, ramp counter cleared.
- ESTOP, estop low → DEAD. Restart after a safety stop always waits out the dead time.
- IDLE, target in≠STOP → RUN. Duties start at 1 and ramp up.
- RUN, target in=STOP → IDLE. Duties go to 1 immediately.
- RUN, target in≠STOP and ≠ current in → DEAD. Outputs in=STOP and duties=1 for DEAD_CYCLES cycles.
- DEAD, counter expires → re-evaluate the target at that cycle. STOP → IDLE; otherwise → RUN with the new in and duties from 1. A source change during DEAD does not restart the counter.
- In RUN with the same in and a new target duty:
  - Increase: ramp by RAMP_STEP per tick, saturating at the target.
  - Decrease: apply immediately.
- Each track ramps independently.
- The ramp tick counter runs 0..RAMP_DIV-1 only in RUN. It clears on entry to RUN.
- grant reflects the winning source in RUN/IDLE/DEAD and 11 in ESTOP.

## Timing
- Reset values: in=0000, duty_cycle_A=duty_cycle_B=1, grant=00, busy=0, state IDLE, all counters 0.
- Input to output latency: 1 cycle (registered), including estop assertion.
- Reversal request at cycle N:
  - in=STOP from N+1 through N+DEAD_CYCLES.
  - New in at N+DEAD_CYCLES+1.
- Ramp timing: first increment at RAMP_DIV cycles after RUN entry, then every RAMP_DIV cycles.
- Ramp arithmetic is done in DUTY_W+1 bits, then saturated to the target. It never wraps.
- Simultaneous events, same cycle:
  - estop and reversal: ESTOP wins.
  - estop deassert and a manual request: DEAD first.
  - Manual drops while auto is valid with a different direction: DEAD.
- Reset mid-DEAD or mid-ramp returns to the reset values asynchronously.

## Structure
- Shared package motor_pkg:
  - Direction codes FORWARD=1001, BACKWARD=0110, LEFT=1010, RIGHT=0101, STOP=0000.
  - Grant codes.
  - DUTY_MIN=1.
- Sub-module duty_ramp, instantiated once per track:
  - Inputs: target, tick, load_min, drop_immediate.
  - Outputs: the current duty and an at_target flag.
- The arbiter mux, state machine, dead counter and tick prescaler live in motor_arbiter.

## Test plan
Bench parameters: DEAD_CYCLES=10, RAMP_STEP=50000, RAMP_DIV=4.

1. Reset check: assert rst mid-run → in=0000, duties=1, grant=00 with no clock edge. Release → outputs unchanged until a request arrives.
2. Soft start: auto_valid with FORWARD, 90000/90000 from IDLE →
   - in=1001, grant=01 one cycle later.
   - Duties 1 → 50001 after 4 cycles → 90000 after 8; busy then drops.
3. Reversal: running FORWARD, auto switches to BACKWARD →
   - in=0000, duties=1 for exactly 10 cycles.
   - Then in=0110 and duties ramp from 1.
4. Estop: estop_cur asserted mid-ramp →
   - Next cycle in=0000, duties=1, grant=11.
   - Release → 10 dead cycles, then resume the auto command.
5. Priority and clamp: man_valid LEFT 300000/300000 together with auto FORWARD →
   - grant=10, DEAD, then in=1010, duties ramp to 250000.
   - man_valid drop → DEAD, then FORWARD.
6. Decrease: running at 250000, target changes to 1 →
   - Next cycle duty=1, in unchanged.
   - A duty of 0 requested is output as 1.
